// File: rtl/bp_pkg.sv
// Shared definitions for the branch direction predictor: counter encodings,
// the default reset value and the table index hash.
package bp_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctrState_e;

  localparam logic [1:0] CTR_INIT_DEFAULT = CTR_WNT;

  // PC is word-addressed, so the low bits are used directly; history is zero-extended by the caller.
  function automatic logic [31:0] bpIndex(input logic [31:0] pc,
                                          input logic [31:0] hist,
                                          input int          indexBits);
    logic [31:0] mask;
    mask = (32'd1 << indexBits) - 32'd1;
    return (pc ^ hist) & mask;
  endfunction

endpackage

// File: rtl/branch_history_predictor_if.sv
// Lookup, training and status signals between decode/execute and the
// direction predictor.
interface branch_history_predictor_if #(
  parameter int LANES = 2
);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANES-1:0]    lookup_valid;
  logic [LANES*32-1:0] lookup_pc;
  logic [LANES-1:0]    predict_taken;
  logic                predict_any;
  logic [LANE_W-1:0]   predict_lane;
  logic                update_valid;
  logic [31:0]         update_pc;
  logic                update_predicted_taken;
  logic                update_wrong;
  logic [15:0]         mispredict_count;

  modport master (
    output lookup_valid, lookup_pc,
    output update_valid, update_pc, update_predicted_taken, update_wrong,
    input  predict_taken, predict_any, predict_lane, mispredict_count
  );

  modport slave (
    input  lookup_valid, lookup_pc,
    input  update_valid, update_pc, update_predicted_taken, update_wrong,
    output predict_taken, predict_any, predict_lane, mispredict_count
  );

endinterface

// File: rtl/bp_sat_ctr.sv
// One 2-bit saturating direction counter; exposes only its taken bit since
// lookups never need the confidence bit.
module bp_sat_ctr
  import bp_pkg::*;
#(
  parameter logic [1:0] CTR_INIT = CTR_INIT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic inc,
  input  logic dec,
  output logic taken
);

  logic [1:0] state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= CTR_INIT;
    end else if (en) begin
      if (inc) begin
        if (state != CTR_ST) state <= state + 2'd1;
      end else if (dec) begin
        if (state != CTR_SNT) state <= state - 2'd1;
      end
    end
  end

  assign taken = state[1];

endmodule

// File: rtl/branch_history_predictor.sv
// Multi-lane branch direction predictor: bimodal or gshare table of
// saturating counters, trained at commit from execute feedback.
module branch_history_predictor
  import bp_pkg::*;
#(
  parameter int         LANES      = 2,
  parameter int         INDEX_BITS = 6,
  parameter int         HIST_BITS  = 0,
  parameter logic [1:0] CTR_INIT   = CTR_INIT_DEFAULT
) (
  input logic                        clock,
  input logic                        reset,
  branch_history_predictor_if.slave  bus
);

  localparam int DEPTH  = 1 << INDEX_BITS;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic                  actualTaken;
  logic [31:0]           ghrExt;
  logic [INDEX_BITS-1:0] updIndex;
  logic [DEPTH-1:0]      ctrTaken;
  logic [INDEX_BITS-1:0] laneIndex [LANES];
  logic [LANES-1:0]      predictTaken;
  logic [LANE_W-1:0]     predictLane;
  logic [15:0]           mispredictCount;

  assign actualTaken = bus.update_predicted_taken ^ bus.update_wrong;

  // History only advances at commit, so lookups and training agree on the hash.
  generate
    if (HIST_BITS > 0) begin : gHist
      logic [HIST_BITS-1:0] ghr;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          ghr <= '0;
        end else if (bus.update_valid) begin
          ghr <= HIST_BITS'({ghr, actualTaken});
        end
      end

      assign ghrExt = 32'(ghr);
    end else begin : gNoHist
      assign ghrExt = '0;
    end
  endgenerate

  assign updIndex = INDEX_BITS'(bpIndex(bus.update_pc, ghrExt, INDEX_BITS));

  for (genvar g = 0; g < DEPTH; g++) begin : gCtr
    bp_sat_ctr #(
      .CTR_INIT (CTR_INIT)
    ) uCtr (
      .clock (clock),
      .reset (reset),
      .en    (bus.update_valid && (updIndex == INDEX_BITS'(g))),
      .inc   (actualTaken),
      .dec   (~actualTaken),
      .taken (ctrTaken[g])
    );
  end

  // Reads see registered state only, so a same-cycle update is not bypassed.
  always_comb begin
    laneIndex    = '{default: '0};
    predictTaken = '0;
    for (int i = 0; i < LANES; i++) begin
      laneIndex[i]    = INDEX_BITS'(bpIndex(bus.lookup_pc[32*i +: 32], ghrExt, INDEX_BITS));
      predictTaken[i] = bus.lookup_valid[i] & ctrTaken[laneIndex[i]];
    end
  end

  // Walk from the youngest lane down so the oldest taken lane wins.
  always_comb begin
    predictLane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (predictTaken[i]) predictLane = LANE_W'(i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mispredictCount <= '0;
    end else if (bus.update_valid && bus.update_wrong && (mispredictCount != 16'hFFFF)) begin
      mispredictCount <= mispredictCount + 16'd1;
    end
  end

  assign bus.predict_taken    = predictTaken;
  assign bus.predict_any      = |predictTaken;
  assign bus.predict_lane     = predictLane;
  assign bus.mispredict_count = mispredictCount;

endmodule

// File: tb/tb_branch_history_predictor.sv
// Directed bench for a bimodal and a gshare predictor instance, with a
// reference model feeding an expectation queue.
module tb_branch_history_predictor;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  branch_history_predictor_if #(.LANES(2)) bus0 ();
  branch_history_predictor_if #(.LANES(2)) bus1 ();

  branch_history_predictor #(
    .LANES(2), .INDEX_BITS(6), .HIST_BITS(0), .CTR_INIT(2'b01)
  ) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  branch_history_predictor #(
    .LANES(2), .INDEX_BITS(6), .HIST_BITS(2), .CTR_INIT(2'b01)
  ) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  typedef struct {
    int          unit;
    logic [1:0]  taken;
    logic        any;
    logic        lane;
    logic [15:0] count;
    string       tag;
  } expect_t;

  expect_t     sbQueue [$];
  logic [1:0]  modelTable [2][64];
  logic [1:0]  modelGhr [2];
  logic [15:0] modelCount [2];
  logic        pendUv [2];
  logic [31:0] pendUpc [2];
  logic        pendUpt [2];
  logic        pendUw [2];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [5:0] modelIdx(input int u, input logic [31:0] pc);
    return pc[5:0] ^ ((u == 1) ? {4'b0000, modelGhr[1]} : 6'b000000);
  endfunction

  task automatic modelReset();
    for (int u = 0; u < 2; u++) begin
      for (int e = 0; e < 64; e++) modelTable[u][e] = 2'b01;
      modelGhr[u]   = 2'b00;
      modelCount[u] = 16'h0000;
    end
  endtask

  task automatic modelCommit();
    logic [5:0] idx;
    logic       actual;
    for (int u = 0; u < 2; u++) begin
      if (pendUv[u]) begin
        idx    = modelIdx(u, pendUpc[u]);
        actual = pendUpt[u] ^ pendUw[u];
        if (actual && modelTable[u][idx] != 2'b11) modelTable[u][idx] = modelTable[u][idx] + 2'b01;
        if (!actual && modelTable[u][idx] != 2'b00) modelTable[u][idx] = modelTable[u][idx] - 2'b01;
        if (u == 1) modelGhr[u] = {modelGhr[u][0], actual};
        if (pendUw[u] && modelCount[u] != 16'hFFFF) modelCount[u] = modelCount[u] + 16'd1;
      end
    end
  endtask

  task automatic driveBus(input int u, input logic [1:0] lv, input logic [31:0] pc0, input logic [31:0] pc1,
                          input logic uv, input logic [31:0] upc, input logic upt, input logic uw);
    if (u == 0) begin
      bus0.lookup_valid = lv;  bus0.lookup_pc = {pc1, pc0};
      bus0.update_valid = uv;  bus0.update_pc = upc;
      bus0.update_predicted_taken = upt;  bus0.update_wrong = uw;
    end else begin
      bus1.lookup_valid = lv;  bus1.lookup_pc = {pc1, pc0};
      bus1.update_valid = uv;  bus1.update_pc = upc;
      bus1.update_predicted_taken = upt;  bus1.update_wrong = uw;
    end
    pendUv[u] = uv;  pendUpc[u] = upc;  pendUpt[u] = upt;  pendUw[u] = uw;
  endtask

  task automatic idleUnit(input int u);
    driveBus(u, 2'b00, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  // Drives one unit and, when chk is set, queues what the model says it must answer.
  task automatic applyStimulus(input int u, input logic [1:0] lv, input logic [31:0] pc0, input logic [31:0] pc1,
                               input logic uv, input logic [31:0] upc, input logic upt, input logic uw,
                               input bit chk, input string tag);
    expect_t e;
    driveBus(u, lv, pc0, pc1, uv, upc, upt, uw);
    if (chk) begin
      e.unit     = u;
      e.taken[0] = lv[0] & modelTable[u][modelIdx(u, pc0)][1];
      e.taken[1] = lv[1] & modelTable[u][modelIdx(u, pc1)][1];
      e.any      = |e.taken;
      e.lane     = ~e.taken[0] & e.taken[1];
      e.count    = modelCount[u];
      e.tag      = tag;
      sbQueue.push_back(e);
    end
  endtask

  task automatic checkOutput();
    expect_t     e;
    logic [1:0]  obsTaken;
    logic        obsAny;
    logic        obsLane;
    logic [15:0] obsCount;
    e = sbQueue.pop_front();
    if (e.unit == 0) begin
      obsTaken = bus0.predict_taken;  obsAny = bus0.predict_any;
      obsLane  = bus0.predict_lane;   obsCount = bus0.mispredict_count;
    end else begin
      obsTaken = bus1.predict_taken;  obsAny = bus1.predict_any;
      obsLane  = bus1.predict_lane;   obsCount = bus1.mispredict_count;
    end
    vectors++;
    assert (obsTaken === e.taken) else begin
      miscompares++;
      $error("[TB] FAIL %s u%0d predict_taken: observed %b expected %b", e.tag, e.unit, obsTaken, e.taken);
    end
    vectors++;
    assert (obsAny === e.any) else begin
      miscompares++;
      $error("[TB] FAIL %s u%0d predict_any: observed %b expected %b", e.tag, e.unit, obsAny, e.any);
    end
    vectors++;
    assert (obsLane === e.lane) else begin
      miscompares++;
      $error("[TB] FAIL %s u%0d predict_lane: observed %b expected %b", e.tag, e.unit, obsLane, e.lane);
    end
    vectors++;
    assert (obsCount === e.count) else begin
      miscompares++;
      $error("[TB] FAIL %s u%0d mispredict_count: observed %h expected %h", e.tag, e.unit, obsCount, e.count);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    while (sbQueue.size() > 0) checkOutput();
    @(posedge clock);
    if (!reset) modelCommit();
    #1;
  endtask

  initial begin
    modelReset();
    idleUnit(0);
    idleUnit(1);
    reset = 1'b1;
    @(posedge clock); #1;

    // Updates while held in reset must be ignored.
    applyStimulus(0, 2'b11, 32'd5, 32'd9, 1'b1, 32'd5, 1'b0, 1'b1, 1'b1, "in_reset");
    tick();
    idleUnit(0);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;

    // gshare: taken then not-taken leaves ghr = 2'b10, swapping entries 0 and 2.
    applyStimulus(1, 2'b00, 32'd0, 32'd0, 1'b1, 32'd2, 1'b1, 1'b0, 1'b1, "gs_upd_taken");
    tick();
    applyStimulus(1, 2'b00, 32'd0, 32'd0, 1'b1, 32'd1, 1'b0, 1'b0, 1'b1, "gs_upd_nt");
    tick();
    applyStimulus(1, 2'b11, 32'd0, 32'd2, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "gs_lookup_0_2");
    tick();
    applyStimulus(1, 2'b11, 32'd2, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "gs_lookup_2_0");
    tick();
    idleUnit(1);

    applyStimulus(0, 2'b11, 32'd5, 32'd9, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "reset_lookup");
    tick();
    applyStimulus(0, 2'b00, 32'd0, 32'd0, 1'b1, 32'd5, 1'b0, 1'b1, 1'b1, "pc5_taken_1");
    tick();
    applyStimulus(0, 2'b00, 32'd0, 32'd0, 1'b1, 32'd5, 1'b0, 1'b1, 1'b1, "pc5_taken_2");
    tick();
    applyStimulus(0, 2'b10, 32'd0, 32'd5, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "lane1_pc5");
    tick();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 2'b00, 32'd0, 32'd0, 1'b1, 32'd5, 1'b0, 1'b0, 1'b1, "pc5_nt");
      tick();
    end
    applyStimulus(0, 2'b01, 32'd5, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "pc5_after_nt");
    tick();
    applyStimulus(0, 2'b00, 32'd0, 32'd0, 1'b1, 32'd69, 1'b1, 1'b0, 1'b1, "alias69_taken");
    tick();
    applyStimulus(0, 2'b11, 32'd5, 32'd69, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "alias_weak");
    tick();
    applyStimulus(0, 2'b00, 32'd0, 32'd0, 1'b1, 32'd5, 1'b1, 1'b0, 1'b1, "pc5_taken_3");
    tick();
    applyStimulus(0, 2'b11, 32'd69, 32'd5, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "alias_taken");
    tick();

    applyStimulus(0, 2'b01, 32'd7, 32'd0, 1'b1, 32'd7, 1'b0, 1'b1, 1'b1, "same_cycle_pc7");
    tick();
    applyStimulus(0, 2'b01, 32'd7, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "next_cycle_pc7");
    tick();

    for (int k = 0; k < 24; k++) begin
      int u;
      u = k % 2;
      idleUnit(1 - u);
      applyStimulus(u, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, "mixed");
      tick();
    end
    idleUnit(0);
    idleUnit(1);

    for (int n = 0; n < 65537; n++) begin
      applyStimulus(0, 2'b00, 32'd0, 32'd0, 1'b1, 32'(n), 1'b0, 1'b1, 1'b0, "");
      tick();
    end
    applyStimulus(0, 2'b00, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "count_saturated");
    tick();

    // Reset lands mid-cycle while a mispredict update is being presented.
    applyStimulus(0, 2'b11, 32'd5, 32'd9, 1'b1, 32'd9, 1'b0, 1'b1, 1'b0, "");
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    applyStimulus(0, 2'b11, 32'd5, 32'd9, 1'b1, 32'd9, 1'b0, 1'b1, 1'b1, "reset_mid_update");
    #1;
    checkOutput();
    tick();
    applyStimulus(0, 2'b11, 32'd5, 32'd9, 1'b1, 32'd9, 1'b0, 1'b1, 1'b1, "reset_hold");
    tick();
    idleUnit(0);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;

    // One taken step from 01 must flip every entry to predict taken.
    for (int e = 0; e < 64; e++) begin
      applyStimulus(0, 2'b00, 32'd0, 32'd0, 1'b1, 32'(e), 1'b1, 1'b0, 1'b0, "");
      tick();
    end
    for (int e = 0; e < 32; e++) begin
      applyStimulus(0, 2'b11, 32'(2 * e), 32'(2 * e + 1), 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "post_reset_entries");
      tick();
    end
    idleUnit(0);
    applyStimulus(1, 2'b11, 32'd0, 32'd2, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, "gs_post_reset");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
